// File: rtl/dbg_pkg.sv
// Shared debugger definitions: dump FSM/section encodings, the section-walk helper,
// default widths and the host command codes.
package dbg_pkg;

    localparam int unsigned DEF_DATA_SZ  = 32;
    localparam int unsigned DEF_ADDR_W   = 5;
    localparam int unsigned DEF_NUM_REGS = 32;
    localparam int unsigned DEF_NUM_MEM  = 32;
    localparam int unsigned DEF_N        = 8;
    localparam int unsigned BYTES_PER_WORD = DEF_DATA_SZ / DEF_N;

    localparam logic [7:0] CMD_LOAD_PROG_SIZE = 8'hFE;
    localparam logic [7:0] CMD_RUN            = 8'hF0;
    localparam logic [7:0] CMD_DUMP           = 8'hFD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SEND,
        ST_NEXT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        SEC_PC,
        SEC_REG,
        SEC_MEM
    } sec_e;

    typedef struct packed {
        logic valid;
        sec_e sec;
    } sec_step_t;

    // Next enabled section after cur; valid=0 means the dump is finished.
    function automatic sec_step_t next_section(input sec_e cur, input logic [1:0] sel);
        sec_step_t s;
        s.valid = 1'b0;
        s.sec   = SEC_PC;
        case (cur)
            SEC_PC: begin
                if (sel[0]) begin
                    s.valid = 1'b1;
                    s.sec   = SEC_REG;
                end else if (sel[1]) begin
                    s.valid = 1'b1;
                    s.sec   = SEC_MEM;
                end
            end
            SEC_REG: begin
                if (sel[1]) begin
                    s.valid = 1'b1;
                    s.sec   = SEC_MEM;
                end
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/debug_dump_sequencer_word_serializer.sv
// Loads one word and shifts it out LSB-first as N-bit bytes, one per cycle the
// TX FIFO is not full; flags the cycle the last byte is written.
module word_serializer #(
    parameter int unsigned DATA_SZ = 32,
    parameter int unsigned N       = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [DATA_SZ-1:0] i_word,
    input  logic               i_send,
    input  logic               i_tx_full,
    output logic               o_wr_uart,
    output logic [N-1:0]       o_w_data,
    output logic               o_fire_c,
    output logic               o_last_c
);

    localparam int unsigned BYTES  = DATA_SZ / N;
    localparam int unsigned BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [DATA_SZ-1:0] shreg_q;
    logic [BIDX_W-1:0]  idx_q;
    logic               wr_q;
    logic [N-1:0]       data_q;

    assign o_fire_c  = i_send & ~i_tx_full;
    assign o_last_c  = o_fire_c & (idx_q == BIDX_W'(BYTES - 1));
    assign o_wr_uart = wr_q;
    assign o_w_data  = data_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            shreg_q <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            wr_q <= o_fire_c;
            if (i_load) begin
                shreg_q <= i_word;
                idx_q   <= '0;
            end else if (o_fire_c) begin
                data_q  <= shreg_q[N-1:0];
                shreg_q <= shreg_q >> N;
                idx_q   <= BIDX_W'(idx_q + 1'b1);
            end
        end
    end

endmodule

// File: rtl/debug_dump_sequencer.sv
// Post-halt dump sequencer: walks PC, register file and data memory through the
// pipeline debug port and streams every word little-endian into the UART TX FIFO.
module debug_dump_sequencer
    import dbg_pkg::*;
#(
    parameter int unsigned DATA_SZ  = DEF_DATA_SZ,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned NUM_MEM  = DEF_NUM_MEM,
    parameter int unsigned N        = DEF_N
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [1:0]         i_sel,
    input  logic [DATA_SZ-1:0] i_pc,
    input  logic [DATA_SZ-1:0] i_register_data,
    input  logic [DATA_SZ-1:0] i_memory_data,
    input  logic               i_tx_full,
    output logic [ADDR_W-1:0]  o_addr,
    output logic               o_wr_uart,
    output logic [N-1:0]       o_w_data,
    output logic               o_busy,
    output logic               o_done,
    output logic [15:0]        o_byte_cnt
);

    localparam int unsigned CNT_W = 16;

    state_e              state_q, state_d;
    sec_e                sec_q, sec_d;
    logic [1:0]          sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                load_c, send_c, fire_c, last_c, at_end_c;
    logic [DATA_SZ-1:0]  word_c;
    sec_step_t           step_c;

    assign o_addr     = addr_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_byte_cnt = cnt_q;

    always_comb begin
        case (sec_q)
            SEC_REG: word_c = i_register_data;
            SEC_MEM: word_c = i_memory_data;
            default: word_c = i_pc;
        endcase
        at_end_c = (sec_q == SEC_MEM) ? (addr_q == ADDR_W'(NUM_MEM - 1))
                                      : (addr_q == ADDR_W'(NUM_REGS - 1));
        step_c   = next_section(sec_q, sel_q);
    end

    word_serializer #(
        .DATA_SZ (DATA_SZ),
        .N       (N)
    ) u_ser (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_load    (load_c),
        .i_word    (word_c),
        .i_send    (send_c),
        .i_tx_full (i_tx_full),
        .o_wr_uart (o_wr_uart),
        .o_w_data  (o_w_data),
        .o_fire_c  (fire_c),
        .o_last_c  (last_c)
    );

    // Next-state, address walk and byte accounting
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        load_c  = 1'b0;
        send_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    state_d = ST_LATCH;
                    sec_d   = SEC_PC;
                    sel_d   = i_sel;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            ST_LATCH: begin
                load_c  = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                send_c = 1'b1;
                if (last_c) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (sec_q != SEC_PC && !at_end_c) begin
                    addr_d  = ADDR_W'(addr_q + 1'b1);
                    state_d = ST_LATCH;
                end else begin
                    addr_d = '0;
                    if (step_c.valid) begin
                        sec_d   = step_c.sec;
                        state_d = ST_LATCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over everything, including a byte that would have gone out this cycle.
        if (i_abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            load_c  = 1'b0;
            send_c  = 1'b0;
        end
        if (send_c && fire_c) cnt_d = CNT_W'(cnt_q + 1'b1);
        busy_d = (state_d == ST_LATCH) || (state_d == ST_SEND) || (state_d == ST_NEXT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            sec_q   <= SEC_PC;
            sel_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Bench for debug_dump_sequencer: random memories/PC and backpressure, byte stream
// compared against a list-of-words model of the dump.
module tb_debug_dump_sequencer;

    logic        i_clk = 1'b0;
    logic        i_reset, i_start, i_abort, i_tx_full;
    logic [1:0]  i_sel;
    logic [31:0] i_pc, i_register_data, i_memory_data;
    logic [4:0]  o_addr;
    logic        o_wr_uart, o_busy, o_done;
    logic [7:0]  o_w_data;
    logic [15:0] o_byte_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    logic [31:0] regs[32];
    logic [31:0] mems[32];
    int          done_cnt = 0;
    int          viol     = 0;
    int          bp_mode  = 0;
    int          cyc      = 0;
    logic        full_prev = 1'b0;
    logic        busy_at1;

    always #5 i_clk = ~i_clk;

    debug_dump_sequencer dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_start         (i_start),
        .i_abort         (i_abort),
        .i_sel           (i_sel),
        .i_pc            (i_pc),
        .i_register_data (i_register_data),
        .i_memory_data   (i_memory_data),
        .i_tx_full       (i_tx_full),
        .o_addr          (o_addr),
        .o_wr_uart       (o_wr_uart),
        .o_w_data        (o_w_data),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_byte_cnt      (o_byte_cnt)
    );

    // Pipeline model: combinational reads at the debug address
    always_comb begin
        i_register_data = regs[o_addr];
        i_memory_data   = mems[o_addr];
    end

    always @(posedge i_clk) full_prev = i_tx_full;

    // Backpressure driver plus byte/done monitor
    always @(negedge i_clk) begin
        cyc = cyc + 1;
        case (bp_mode)
            0:       i_tx_full = 1'b0;
            1:       i_tx_full = ((cyc % 3) == 2);
            default: i_tx_full = ($urandom_range(0, 2) == 0);
        endcase
        if (o_wr_uart === 1'b1) begin
            got_q.push_back(o_w_data);
            if (full_prev === 1'b1) viol = viol + 1;
        end
        if (o_done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    endtask

    task automatic build_expected(input logic [1:0] sel);
        exp_q.delete();
        push_word(i_pc);
        if (sel[0]) for (int k = 0; k < 32; k++) push_word(regs[k]);
        if (sel[1]) for (int k = 0; k < 32; k++) push_word(mems[k]);
    endtask

    task automatic randomize_state();
        i_pc = $urandom;
        for (int k = 0; k < 32; k++) begin
            regs[k] = $urandom;
            mems[k] = $urandom;
        end
    endtask

    task automatic check_stream(input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
        n_checks++;
        if (got_q.size() != exp_q.size() || bad >= 0) begin
            n_fail++;
            $display("FAIL %s: got %0d bytes, required %0d; first bad index %0d", name,
                     got_q.size(), exp_q.size(), bad);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Start a dump; returns the number of clock edges from the start edge to o_done.
    task automatic run_dump(input logic [1:0] sel, input int restart_at,
                            input bit start_in_done, output int k_done);
        got_q.delete();
        done_cnt = 0;
        k_done   = -1;
        @(negedge i_clk); #1;
        i_sel   = sel;
        i_start = 1'b1;
        for (int k = 1; k <= 5000 && k_done < 0; k++) begin
            @(negedge i_clk); #1;
            if (k == 1) busy_at1 = o_busy;
            i_start = (k == restart_at);
            if (k == 3) i_sel = ~sel;
            if (o_done === 1'b1) begin
                k_done = k;
                if (start_in_done) i_start = 1'b1;
            end
        end
        @(negedge i_clk); #1;
        i_start = 1'b0;
        n_checks++;
        if (k_done < 0) begin
            n_fail++;
            $display("FAIL run_dump_timeout: no o_done within 5000 cycles, required one");
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(negedge i_clk);
        #1;
        n_checks++;
        if ({o_addr, o_wr_uart, o_w_data, o_busy, o_done, o_byte_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: addr=%h wr=%b data=%h busy=%b done=%b cnt=%0d, required all 0",
                     o_addr, o_wr_uart, o_w_data, o_busy, o_done, o_byte_cnt);
        end
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_pc_only();
        int k;
        randomize_state();
        i_pc = 32'h0000_0008;
        build_expected(2'b00);
        run_dump(2'b00, 0, 1'b0, k);
        check_stream("pc_only_bytes");
        check_int("pc_only_done_latency", k, 7);
        check_int("pc_only_byte_cnt", o_byte_cnt, 4);
        check_int("pc_only_busy_after_start", busy_at1, 1);
        check_int("pc_only_busy_after_done", o_busy, 0);
    endtask

    task automatic test_regs();
        int k;
        randomize_state();
        for (int r = 0; r < 32; r++) regs[r] = r * 32'h0101_0101;
        build_expected(2'b01);
        run_dump(2'b01, 0, 1'b0, k);
        check_stream("regs_bytes");
        check_int("regs_done_latency", k, 199);
        check_int("regs_byte_cnt", o_byte_cnt, 132);
        check_int("regs_addr_end", o_addr, 0);
        check_int("regs_reg2_byte", (got_q.size() > 14) ? int'(got_q[14]) : -1, 2);
    endtask

    task automatic test_backpressure();
        int k;
        randomize_state();
        build_expected(2'b11);
        viol    = 0;
        bp_mode = 1;
        run_dump(2'b11, 0, 1'b0, k);
        bp_mode = 0;
        check_stream("bp3_bytes");
        check_int("bp3_write_while_full", viol, 0);
        check_int("bp3_byte_cnt", o_byte_cnt, 260);
        for (int t = 0; t < 2; t++) begin
            logic [1:0] sel;
            sel = 2'($urandom_range(0, 3));
            randomize_state();
            build_expected(sel);
            viol    = 0;
            bp_mode = 2;
            run_dump(sel, 0, 1'b0, k);
            bp_mode = 0;
            check_stream("bprand_bytes");
            check_int("bprand_write_while_full", viol, 0);
            check_int("bprand_byte_cnt", o_byte_cnt, 4 * (1 + 32 * int'(sel[0]) + 32 * int'(sel[1])));
        end
    endtask

    task automatic test_abort();
        int k;
        bit hit;
        randomize_state();
        got_q.delete();
        done_cnt = 0;
        hit      = 1'b0;
        @(negedge i_clk); #1;
        i_sel   = 2'b11;
        i_start = 1'b1;
        @(negedge i_clk); #1;
        i_start = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            if (got_q.size() >= 10) hit = 1'b1;
            else begin
                @(negedge i_clk); #1;
            end
        end
        check_int("abort_reached_10th_byte", int'(hit), 1);
        i_abort = 1'b1;
        i_start = 1'b1;
        @(negedge i_clk); #1;
        i_abort = 1'b0;
        i_start = 1'b0;
        check_int("abort_busy", o_busy, 0);
        check_int("abort_addr", o_addr, 0);
        check_int("abort_byte_cnt", o_byte_cnt, 10);
        repeat (20) @(negedge i_clk);
        #1;
        check_int("abort_no_done", done_cnt, 0);
        check_int("abort_no_more_bytes", got_q.size(), 10);
        build_expected(2'b11);
        run_dump(2'b11, 0, 1'b0, k);
        check_stream("after_abort_bytes");
        check_int("after_abort_byte_cnt", o_byte_cnt, 260);
    endtask

    task automatic test_back_to_back();
        int k;
        randomize_state();
        build_expected(2'b11);
        run_dump(2'b11, 50, 1'b1, k);
        repeat (10) @(negedge i_clk);
        #1;
        check_int("b2b_done_latency", k, 391);
        check_int("b2b_single_done", done_cnt, 1);
        check_int("b2b_busy_after", o_busy, 0);
        check_int("b2b_byte_cnt", o_byte_cnt, 260);
        check_stream("b2b_bytes");
    endtask

    task automatic test_async_reset();
        int n;
        bit hit;
        randomize_state();
        got_q.delete();
        hit = 1'b0;
        @(negedge i_clk); #1;
        i_sel   = 2'b11;
        i_start = 1'b1;
        @(negedge i_clk); #1;
        i_start = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            if (got_q.size() >= 6 && o_wr_uart === 1'b1) hit = 1'b1;
            else begin
                @(negedge i_clk); #1;
            end
        end
        check_int("arst_reached_send", int'(hit), 1);
        #2;
        i_reset = 1'b1;
        #1;
        n_checks++;
        if ({o_addr, o_wr_uart, o_w_data, o_busy, o_done, o_byte_cnt} !== '0) begin
            n_fail++;
            $display("FAIL arst_immediate: addr=%h wr=%b data=%h busy=%b done=%b cnt=%0d, required all 0",
                     o_addr, o_wr_uart, o_w_data, o_busy, o_done, o_byte_cnt);
        end
        @(negedge i_clk); #1;
        i_reset = 1'b0;
        n = got_q.size();
        repeat (50) @(negedge i_clk);
        #1;
        check_int("arst_no_writes_after", got_q.size(), n);
        check_int("arst_idle_after", o_busy, 0);
    endtask

    initial begin
        i_reset   = 1'b1;
        i_start   = 1'b0;
        i_abort   = 1'b0;
        i_sel     = 2'b00;
        i_pc      = '0;
        i_tx_full = 1'b0;
        for (int k = 0; k < 32; k++) begin
            regs[k] = '0;
            mems[k] = '0;
        end
        test_reset();
        test_pc_only();
        test_regs();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
